// File: rtl/rv_mem_arb_pkg.sv
// rtl/rv_mem_arb_pkg.sv - shared types and constants for the rv_core memory arbiter
package pkg_rv_arb;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_IFETCH = 1'b1
  } arb_state_t;

  // Which core port(s) receive the read word returned in the following cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2,
    OWN_BOTH = 2'd3
  } owner_t;

  // d_adr[31:16] value decoded as core-internal I/O (mtime/mtimecmp)
  localparam logic [15:0] IO_HI_DEFAULT = 16'hffff;

endpackage

// File: rtl/rv_arb_rdmux.sv
// rtl/rv_arb_rdmux.sv - read-return steering and stall-hold registers for i_dr/d_dr
module rv_arb_rdmux
  import pkg_rv_arb::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  owner_t      owner_nxt,
  input  logic [31:0] m_dr,
  input  logic [31:0] dh_q,
  output logic [31:0] i_dr,
  output logic [31:0] d_dr
);

  owner_t      own_q;
  logic        fresh_q;
  logic [31:0] i_mux;
  logic [31:0] d_mux;
  logic [31:0] i_hold;
  logic [31:0] d_hold;

  // Steer the live memory word (and the parked data word) to the owning port(s)
  always_comb begin
    i_mux = 32'h0;
    d_mux = 32'h0;
    case (own_q)
      OWN_I:    i_mux = m_dr;
      OWN_D:    d_mux = m_dr;
      OWN_BOTH: begin
        i_mux = m_dr;
        d_mux = dh_q;
      end
      default: ;
    endcase
  end

  // Track the owner of the next return and freeze returned words while the core stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      own_q   <= OWN_NONE;
      fresh_q <= 1'b0;
      i_hold  <= 32'h0;
      d_hold  <= 32'h0;
    end else begin
      fresh_q <= rdy;
      if (rdy) own_q <= owner_nxt;
      if (fresh_q) begin
        i_hold <= i_mux;
        d_hold <= d_mux;
      end
    end
  end

  // m_dr is only meaningful right after an rdy cycle; otherwise replay the held copy
  assign i_dr = fresh_q ? i_mux : i_hold;
  assign d_dr = fresh_q ? d_mux : d_hold;

endmodule

// File: rtl/rv_mem_arb.sv
// rtl/rv_mem_arb.sv - fetch/data arbiter onto one single-port memory (option: RV_ARB_PERFCNT_EN)
module rv_mem_arb
  import pkg_rv_arb::*;
#(
  parameter logic [15:0] IO_HI = IO_HI_DEFAULT,
  parameter int          AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   i_adr,
  input  logic          i_re,
  output logic [31:0]   i_dr,
  output logic          i_rdy,
  input  logic [31:0]   d_adr,
  input  logic          d_re,
  input  logic [31:0]   d_dw,
  input  logic [3:0]    d_we,
  output logic [31:0]   d_dr,
  output logic          d_rdy,
  output logic [AW-1:0] m_adr,
  output logic          m_re,
  output logic [3:0]    m_we,
  output logic [31:0]   m_dw,
  input  logic [31:0]   m_dr,
  input  logic          m_rdy
`ifdef RV_ARB_PERFCNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  arb_state_t  state;
  arb_state_t  state_nxt;
  owner_t      owner_nxt;
  logic        rdy;
  logic        dacc;
  logic        conflict;
  logic [AW-1:0] ia_q;
  logic        pend_d;
  logic        d_rd_q;
  logic [31:0] dh_q;

  // I/O-window data accesses never touch memory, so they cannot collide with a fetch
  assign dacc     = (d_re | (|d_we)) & (d_adr[31:16] != IO_HI);
  assign conflict = i_re & dacc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Next state: a conflict moves on to the deferred fetch once memory takes the data access
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (conflict && m_rdy) state_nxt = ST_IFETCH;
      ST_IFETCH: if (m_rdy)             state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Outputs: memory request, core handshake and the owner of the next read return
  always_comb begin
    m_adr     = '0;
    m_re      = 1'b0;
    m_we      = 4'h0;
    m_dw      = 32'h0;
    rdy       = 1'b0;
    owner_nxt = OWN_NONE;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (dacc) begin
            m_adr     = d_adr[AW-1:0];
            m_re      = d_re;
            m_we      = d_we;
            m_dw      = d_dw;
            owner_nxt = d_re ? OWN_D : OWN_NONE;
          end else begin
            m_adr     = i_adr[AW-1:0];
            m_re      = i_re;
            owner_nxt = i_re ? OWN_I : OWN_NONE;
          end
          rdy = conflict ? 1'b0 : m_rdy;
        end
        ST_IFETCH: begin
          m_adr     = ia_q;
          m_re      = 1'b1;
          rdy       = m_rdy;
          owner_nxt = OWN_BOTH;
        end
        default: ;
      endcase
    end
  end

  assign i_rdy = rdy;
  assign d_rdy = rdy;

  // Park the deferred fetch address, then grab the data read word on the first IFETCH cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ia_q   <= '0;
      pend_d <= 1'b0;
      d_rd_q <= 1'b0;
      dh_q   <= 32'h0;
    end else if (state == ST_RUN) begin
      if (conflict && m_rdy) begin
        ia_q   <= i_adr[AW-1:0];
        pend_d <= 1'b1;
        d_rd_q <= d_re;
      end
    end else if (pend_d) begin
      dh_q   <= d_rd_q ? m_dr : 32'h0;
      pend_d <= 1'b0;
    end
  end

  rv_arb_rdmux u_rdmux (
    .clk       (clk),
    .reset     (reset),
    .rdy       (rdy),
    .owner_nxt (owner_nxt),
    .m_dr      (m_dr),
    .dh_q      (dh_q),
    .i_dr      (i_dr),
    .d_dr      (d_dr)
  );

`ifdef RV_ARB_PERFCNT_EN
  // Count every core stall cycle outside reset, wrapping naturally at 32 bits
  always_ff @(posedge clk) begin
    if (reset)     stall_cnt <= 32'h0;
    else if (!rdy) stall_cnt <= stall_cnt + 32'h1;
  end
`endif

endmodule

// File: tb/tb_rv_mem_arb.sv
// tb/tb_rv_mem_arb.sv - directed self-checking bench for rv_mem_arb
module tb_rv_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_adr;
  logic        i_re;
  logic [31:0] i_dr;
  logic        i_rdy;
  logic [31:0] d_adr;
  logic        d_re;
  logic [31:0] d_dw;
  logic [3:0]  d_we;
  logic [31:0] d_dr;
  logic        d_rdy;
  logic [31:0] m_adr;
  logic        m_re;
  logic [3:0]  m_we;
  logic [31:0] m_dw;
  logic [31:0] m_dr = 32'h0;
  logic        m_rdy;
`ifdef RV_ARB_PERFCNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv_mem_arb dut (
    .clk   (clk),
    .reset (reset),
    .i_adr (i_adr),
    .i_re  (i_re),
    .i_dr  (i_dr),
    .i_rdy (i_rdy),
    .d_adr (d_adr),
    .d_re  (d_re),
    .d_dw  (d_dw),
    .d_we  (d_we),
    .d_dr  (d_dr),
    .d_rdy (d_rdy),
    .m_adr (m_adr),
    .m_re  (m_re),
    .m_we  (m_we),
    .m_dw  (m_dw),
    .m_dr  (m_dr),
    .m_rdy (m_rdy)
`ifdef RV_ARB_PERFCNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  // Memory model: 1-cycle read latency, garbage on the bus when no read was accepted
  always @(posedge clk) begin
    if (m_re && m_rdy) m_dr <= memf(m_adr);
    else               m_dr <= 32'hbad0bad0;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_re = 1'b0; i_adr = 32'h0;
    d_re = 1'b0; d_we = 4'h0; d_adr = 32'h0; d_dw = 32'h0;
  endtask

  initial begin
    reset = 1'b1; m_rdy = 1'b1;
    idle();
    tick(); tick();
    #1;
    check("rst_m_re",  {31'b0, m_re}, 32'h0);
    check("rst_m_we",  {28'b0, m_we}, 32'h0);
    check("rst_m_adr", m_adr, 32'h0);
    check("rst_rdy",   {30'b0, i_rdy, d_rdy}, 32'h0);
    check("rst_i_dr",  i_dr, 32'h0);
    check("rst_d_dr",  d_dr, 32'h0);
    tick();

    // Fetch only
    reset = 1'b0;
    i_re = 1'b1; i_adr = 32'h100;
    #1;
    check("f_m_adr", m_adr, 32'h100);
    check("f_m_re",  {31'b0, m_re}, 32'h1);
    check("f_rdy",   {30'b0, i_rdy, d_rdy}, 32'h3);
    tick();
    i_adr = 32'h108;
    #1;
    check("f_i_dr",  i_dr, memf(32'h100));
    check("f_d_dr",  d_dr, 32'h0);
    check("f_rdy2",  {30'b0, i_rdy, d_rdy}, 32'h3);
    check("f_m_adr2", m_adr, 32'h108);
    tick();

    // Conflict load
    i_adr = 32'h104; d_re = 1'b1; d_adr = 32'h2000;
    #1;
    check("cl0_m_adr", m_adr, 32'h2000);
    check("cl0_m_re",  {31'b0, m_re}, 32'h1);
    check("cl0_rdy",   {30'b0, i_rdy, d_rdy}, 32'h0);
    check("cl0_i_dr",  i_dr, memf(32'h108));
    tick();
    #1;
    check("cl1_m_adr", m_adr, 32'h104);
    check("cl1_m_we",  {28'b0, m_we}, 32'h0);
    check("cl1_rdy",   {30'b0, i_rdy, d_rdy}, 32'h3);
    check("cl1_i_hold", i_dr, memf(32'h108));
    tick();
    idle();
    #1;
    check("cl2_d_dr", d_dr, memf(32'h2000));
    check("cl2_i_dr", i_dr, memf(32'h104));
    tick();
    #1;
    check("idle_i_dr", i_dr, 32'h0);
    check("idle_d_dr", d_dr, 32'h0);

    // Conflict store
    i_re = 1'b1; i_adr = 32'h10c; d_we = 4'b0011; d_adr = 32'h2002; d_dw = 32'h0000beef;
    #1;
    check("cs0_m_we",  {28'b0, m_we}, 32'h3);
    check("cs0_m_adr", m_adr, 32'h2002);
    check("cs0_m_dw",  m_dw, 32'h0000beef);
    check("cs0_rdy",   {30'b0, i_rdy, d_rdy}, 32'h0);
    tick();
    #1;
    check("cs1_m_adr", m_adr, 32'h10c);
    check("cs1_m_we",  {28'b0, m_we}, 32'h0);
    check("cs1_rdy",   {30'b0, i_rdy, d_rdy}, 32'h3);
    tick();
    idle();
    #1;
    check("cs2_i_dr", i_dr, memf(32'h10c));
    check("cs2_d_dr", d_dr, 32'h0);
    tick();

    // I/O bypass alongside a fetch
    i_re = 1'b1; i_adr = 32'h110; d_re = 1'b1; d_adr = 32'hffff8000;
    #1;
    check("io_rdy",   {30'b0, i_rdy, d_rdy}, 32'h3);
    check("io_m_adr", m_adr, 32'h110);
    check("io_m_we",  {28'b0, m_we}, 32'h0);
    tick();
    idle();
    #1;
    check("io_i_dr", i_dr, memf(32'h110));
    check("io_d_dr", d_dr, 32'h0);
    tick();

    // m_rdy low for 3 cycles in IFETCH, starting from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_re = 1'b1; i_adr = 32'h120; d_re = 1'b1; d_adr = 32'h3000;
    #1;
    check("ms0_rdy", {30'b0, i_rdy, d_rdy}, 32'h0);
    tick();
    m_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("ms_rdy",   {30'b0, i_rdy, d_rdy}, 32'h0);
      check("ms_m_adr", m_adr, 32'h120);
      check("ms_m_re",  {31'b0, m_re}, 32'h1);
      tick();
    end
    m_rdy = 1'b1;
    #1;
    check("ms4_rdy",   {30'b0, i_rdy, d_rdy}, 32'h3);
    check("ms4_m_adr", m_adr, 32'h120);
    tick();
    idle();
    #1;
    check("ms5_d_dr", d_dr, memf(32'h3000));
    check("ms5_i_dr", i_dr, memf(32'h120));
`ifdef RV_ARB_PERFCNT_EN
    check("ms5_stall_cnt", stall_cnt, 32'd4);
`endif
    tick();

    // Reset asserted while in IFETCH
    i_re = 1'b1; i_adr = 32'h130; d_re = 1'b1; d_adr = 32'h3004;
    tick();
    m_rdy = 1'b0;
    #1;
    check("ri_m_adr", m_adr, 32'h130);
    reset = 1'b1;
    tick();
    idle();
    #1;
    check("ri_m_re", {31'b0, m_re}, 32'h0);
    check("ri_rdy",  {30'b0, i_rdy, d_rdy}, 32'h0);
    check("ri_i_dr", i_dr, 32'h0);
`ifdef RV_ARB_PERFCNT_EN
    check("ri_stall_cnt", stall_cnt, 32'd0);
`endif
    tick();
    reset = 1'b0; m_rdy = 1'b1;
    i_re = 1'b1; i_adr = 32'h140;
    #1;
    check("rr_m_adr", m_adr, 32'h140);
    check("rr_rdy",   {30'b0, i_rdy, d_rdy}, 32'h3);
    tick();
    idle();
    #1;
    check("rr_i_dr", i_dr, memf(32'h140));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_mem_arb.md
Name: rv_mem_arb

Overview:
- Arbitrates rv_core's instruction-fetch port and data port onto one single-port synchronous memory. The memory has 1-cycle read latency and a ready input.
- Sits between rv_core and the program/data RAM or bus bridge.
- On a fetch/data conflict it inserts exactly one core stall (i_rdy = d_rdy = 0). It then serialises data-first, fetch-second, and returns both read words together.

Parameters:
IO_HI, 16'hffff, d_adr[31:16] value for core-internal I/O (mtime/mtimecmp); such data accesses bypass memory
AW, 32, memory address width (m_adr = low AW bits of the selected address)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_adr  in  32  core fetch address
i_re  in  1  core fetch enable
i_dr  out  32  fetch read data to core
i_rdy  out  1  ready to core fetch port
d_adr  in  32  core data address
d_re  in  1  core data read enable
d_dw  in  32  core write data (pre-lane-aligned)
d_we  in  4  core byte write enables
d_dr  out  32  data read data to core
d_rdy  out  1  ready to core data port
m_adr  out  AW  memory address
m_re  out  1  memory read enable
m_we  out  4  memory byte write enables
m_dw  out  32  memory write data
m_dr  in  32  memory read data, valid the cycle after an accepted read
m_rdy  in  1  memory accepts/completes the current request this cycle

Behaviour:
- Definitions:
  - dacc = (d_re | |d_we) & (d_adr[31:16] != IO_HI).
  - conflict = i_re & dacc.
- i_rdy and d_rdy are always equal; both are called rdy below. Core signals are sampled only where stated.
- FSM states: RUN, IFETCH. Reset enters RUN.
- RUN, no conflict:
  - If dacc is set, the memory port carries the data request (m_adr = d_adr, m_re = d_re, m_we = d_we, m_dw = d_dw). Otherwise it carries the fetch (m_adr = i_adr, m_re = i_re, m_we = 0).
  - rdy = m_rdy. The owner (I, D or NONE) is registered when rdy = 1.
- RUN, conflict:
  - Memory carries the data request; rdy = 0.
  - If m_rdy = 1: latch i_adr into ia_q, set pend_d, go to IFETCH.
  - If m_rdy = 0: stay in RUN with the memory outputs held.
- IFETCH:
  - Memory carries m_adr = ia_q, m_re = 1, m_we = 0.
  - On the first IFETCH cycle, m_dr is captured into dh_q (the data read result).
  - rdy = m_rdy. When m_rdy = 1, go to RUN with owner = BOTH.
- Read return, in the cycle after an rdy = 1 cycle:
  - Owner I: i_dr = m_dr, d_dr = 0.
  - Owner D: d_dr = m_dr, i_dr = 0.
  - Owner BOTH: i_dr = m_dr, d_dr = dh_q.
  - Owner NONE: both 0.
  - I/O-bypass reads return d_dr = 0; the core ORs in its own I/O data.
- Returned data stays stable while rdy = 0, using registered m_dr capture on stall.
- Writes: a conflict write completes in its RUN cycle and dh_q is don't-care; d_dr = 0.
- Timing:
  - Conflict costs exactly one rdy = 0 cycle when m_rdy is held at 1.
  - m_rdy = 0 extends the current state with all m_* outputs held.
- Reset:
  - m_re = 0, m_we = 0, m_adr = 0, m_dw = 0, i_dr = d_dr = 0, rdy = 0. Owner = NONE, pend_d = 0, dh_q = 0, ia_q = 0.
  - Reset asserted mid-IFETCH aborts the fetch. The core is also reset, so there is no replay.
- Simultaneous events:
  - Reset has priority over m_rdy.
  - An I/O-bypass access together with a fetch is not a conflict.

Optional Feature:
- RV_ARB_PERFCNT_EN defined:
  - Adds output stall_cnt[31:0], reset to 0.
  - Increments by 1 on every cycle with rdy = 0 and reset = 0, including m_rdy-induced stalls.
  - Wraps from 0xffffffff to 0.
- Undefined: port absent, no counter logic; behaviour otherwise identical.

Decomposition:
- Package pkg_rv_arb holds:
  - arb_state_t (RUN, IFETCH)
  - owner_t (NONE, I, D, BOTH)
  - default IO_HI constant
- Sub-module rv_arb_rdmux: read-return mux plus stall-hold registers for i_dr/d_dr. The FSM stays in rv_mem_arb.

Test Plan:
- Fetch only (i_adr = 0x100, d_re = 0, m_rdy = 1) -> rdy = 1 every cycle; m_adr = 0x100; next cycle i_dr = m_dr.
- Conflict load (i_adr = 0x104, d_re = 1, d_adr = 0x2000) -> cycle 0: m_adr = 0x2000, rdy = 0; cycle 1: m_adr = 0x104, rdy = 1; cycle 2: d_dr = mem[0x2000], i_dr = mem[0x104].
- Conflict store (d_we = 4'b0011, d_adr = 0x2002, d_dw = 0x0000beef) -> m_we = 4'b0011 in cycle 0, fetch in cycle 1, exactly one stall cycle, d_dr = 0.
- I/O bypass (d_re = 1, d_adr = 0xffff8000, fetch active) -> no conflict, rdy = 1, m_adr = i_adr, d_dr = 0.
- m_rdy low for 3 cycles during IFETCH -> rdy = 0 for 4 total cycles, m_adr = ia_q held, data correct on release; stall_cnt = 4 when RV_ARB_PERFCNT_EN is defined.
- Reset asserted in IFETCH -> next cycle state RUN, m_re = 0, rdy = 0, stall_cnt = 0.
